// File: rtl/mmcm_drp_reconfig.sv
// DRP read-modify-write sequencer for a running MMCME2_ADV: holds the MMCM in reset
// while a host-supplied command stream is applied, then releases it and waits for lock.
module mmcm_drp_reconfig #(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic [15:0] cmd_mask,
    input  logic        cmd_last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic        mmcm_rst,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic [15:0] drp_do,
    input  logic        drdy,
    input  logic        locked
);

    localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DRDY_LAST = TW'(DRDY_TIMEOUT - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_SAT = '1;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DRDY = 2'b01;
    localparam logic [1:0] ERR_LOCK = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_WAIT_R, S_WR, S_WAIT_W,
        S_NEXT, S_REL, S_WAIT_L, S_FAIL, S_DONE
    } state_t;

    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic [1:0]    lock_sync_reg;
    logic [15:0]   data_reg;
    logic [15:0]   mask_reg;
    logic          last_reg;
    logic          accept;

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            lock_sync_reg <= 2'b00;
            data_reg      <= '0;
            mask_reg      <= '0;
            last_reg      <= 1'b0;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= ERR_OK;
            mmcm_rst      <= 1'b0;
            daddr         <= '0;
            den           <= 1'b0;
            dwe           <= 1'b0;
            di            <= '0;
        end else begin
            lock_sync_reg <= {lock_sync_reg[0], locked};
            done          <= 1'b0;
            den           <= 1'b0;
            dwe           <= 1'b0;

            case (state_reg)
                S_IDLE, S_NEXT: begin
                    if (accept) begin
                        daddr     <= cmd_addr;
                        data_reg  <= cmd_data;
                        mask_reg  <= cmd_mask;
                        last_reg  <= cmd_last;
                        err       <= ERR_OK;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        mmcm_rst  <= 1'b1;
                        den       <= 1'b1;
                        state_reg <= S_RD;
                    end
                end
                S_RD: begin
                    timer_reg <= '0;
                    state_reg <= S_WAIT_R;
                end
                S_WAIT_R: begin
                    if (drdy) begin
                        // Masked merge: mask bit 1 keeps the bit just read back.
                        di        <= (drp_do & mask_reg) | (data_reg & ~mask_reg);
                        den       <= 1'b1;
                        dwe       <= 1'b1;
                        state_reg <= S_WR;
                    end else if (timer_reg == DRDY_LAST) begin
                        err       <= ERR_DRDY;
                        mmcm_rst  <= 1'b0;
                        state_reg <= S_FAIL;
                    end else if (timer_reg != TIMER_SAT) begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                S_WR: begin
                    timer_reg <= '0;
                    state_reg <= S_WAIT_W;
                end
                S_WAIT_W: begin
                    if (drdy) begin
                        if (last_reg) begin
                            mmcm_rst  <= 1'b0;
                            state_reg <= S_REL;
                        end else begin
                            cmd_ready <= 1'b1;
                            state_reg <= S_NEXT;
                        end
                    end else if (timer_reg == DRDY_LAST) begin
                        err       <= ERR_DRDY;
                        mmcm_rst  <= 1'b0;
                        state_reg <= S_FAIL;
                    end else if (timer_reg != TIMER_SAT) begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                S_REL: begin
                    timer_reg <= '0;
                    state_reg <= S_WAIT_L;
                end
                S_WAIT_L: begin
                    if (lock_sync_reg[1]) begin
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (timer_reg == LOCK_LAST) begin
                        err       <= ERR_LOCK;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (timer_reg != TIMER_SAT) begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                S_FAIL: begin
                    // MMCM is already out of reset here and tries to lock on the partial config.
                    done      <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: a DRP register-file/MMCM model plus a command-level
// golden register image; directed scenarios followed by randomized command sequences.
module tb_mmcm_drp_reconfig;

    localparam int DRDY_TO = 8;
    localparam int LOCK_TO = 40;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [15:0] cmd_mask;
    logic        cmd_last;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        mmcm_rst;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] drp_do;
    logic        drdy;
    logic        locked;

    mmcm_drp_reconfig #(
        .DRDY_TIMEOUT(DRDY_TO),
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_mask (cmd_mask),
        .cmd_last (cmd_last),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mmcm_rst (mmcm_rst),
        .daddr    (daddr),
        .den      (den),
        .dwe      (dwe),
        .di       (di),
        .drp_do   (drp_do),
        .drdy     (drdy),
        .locked   (locked)
    );

    initial forever #5 clk_in = ~clk_in;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [6:0]  a;
        logic [15:0] d;
    } drp_t;

    drp_t        txq[$];
    drp_t        expq[$];
    int          tx_cyc[$];
    logic [15:0] mem  [128];
    logic [15:0] gmem [128];

    int          cyc = 0;
    int          lat = 3;
    bit          no_drdy = 0;
    bit          spur_rd = 0;
    bit          spur_idle = 0;
    int          lock_dly = 10;
    bit          lock_hold = 0;
    int          pend = 0;
    logic [15:0] pend_data = '0;
    bit          pend_we = 0;
    int          lock_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [1:0]  done_err = '0;
    int          rst_fall_cnt = 0;
    int          rst_fall_cyc = 0;
    int          wdrdy_cyc = 0;
    bit          in_cmd = 0;
    logic        prev_ready = 1'b0;
    logic        prev_den = 1'b0;
    logic        prev_mrst = 1'b0;

    // DRP slave + MMCM model, observed just after every rising edge.
    initial begin
        drdy   = 1'b0;
        drp_do = '0;
        locked = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            drdy = 1'b0;
            if (rst) begin
                in_cmd = 0;
            end else begin
                if (cmd_valid && prev_ready) in_cmd = 1;
                if (in_cmd) chk("ready_low_in_cmd", cmd_ready, 0);
                if (busy && cmd_ready) chk("rst_held_in_next", mmcm_rst, 1);
            end
            if (spur_idle) begin
                drdy      = 1'b1;
                drp_do    = 16'hBEEF;
                spur_idle = 0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drdy   = 1'b1;
                    drp_do = pend_data;
                    if (pend_we) begin
                        wdrdy_cyc = cyc;
                        in_cmd    = 0;
                    end
                end
            end
            if (den) begin
                chk("den_spacing", prev_den, 0);
                chk("rst_during_drp", mmcm_rst, 1);
                chk("one_outstanding", pend, 0);
                txq.push_back({dwe, daddr, di});
                tx_cyc.push_back(cyc);
                $display("  drp %s addr=0x%02h di=0x%04h cycle=%0d", dwe ? "WR" : "RD", daddr, di, cyc);
                if (dwe) mem[daddr] = di;
                if (!no_drdy) begin
                    pend      = lat;
                    pend_data = dwe ? 16'h0000 : mem[daddr];
                    pend_we   = dwe;
                end
                if (spur_rd && !dwe) begin
                    drdy    = 1'b1;
                    drp_do  = 16'hDEAD;
                    spur_rd = 0;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = err;
                in_cmd   = 0;
                $display("  done err=%0b cycle=%0d", err, cyc);
            end
            if (prev_mrst && !mmcm_rst) begin
                rst_fall_cnt++;
                rst_fall_cyc = cyc;
            end
            if (mmcm_rst || lock_hold) begin
                locked   = 1'b0;
                lock_cnt = 0;
            end else if (lock_cnt < lock_dly) begin
                lock_cnt++;
            end else begin
                locked = 1'b1;
            end
            prev_ready = cmd_ready;
            prev_den   = den;
            prev_mrst  = mmcm_rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic clear_q();
        txq.delete();
        expq.delete();
        tx_cyc.delete();
    endtask

    task automatic sync_gmem();
        for (int i = 0; i < 128; i++) gmem[i] = mem[i];
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m, input bit last);
        int          n;
        logic [15:0] nv;
        n  = 0;
        nv = (gmem[a] & m) | (d & ~m);
        expq.push_back({1'b0, a, 16'h0000});
        expq.push_back({1'b1, a, nv});
        gmem[a] = nv;
        @(negedge clk_in);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_mask  = m;
        cmd_last  = last;
        while (!cmd_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        $display("cmd addr=0x%02h data=0x%04h mask=0x%04h last=%0b", a, d, m, last);
        @(negedge clk_in);
        cmd_valid = 1'b0;
        chk("rd_after_accept", {den, dwe, daddr}, {1'b1, 1'b0, a});
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        chk("done_seen", done_cnt - d0, 1);
        chk("busy_in_done", {busy, done}, {1'b1, 1'b1});
        @(negedge clk_in);
        chk("idle_after_done", {busy, done, cmd_ready}, {1'b0, 1'b0, 1'b1});
    endtask

    task automatic check_txq();
        chk("tx_count", txq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
            chk("tx_kind_addr", {txq[i].we, txq[i].a}, {expq[i].we, expq[i].a});
            if (expq[i].we) chk("tx_wdata", txq[i].d, expq[i].d);
        end
    endtask

    task automatic finish_ok(input int d0, input int f0);
        wait_done(d0);
        chk("err_ok", done_err, 2'b00);
        chk("err_held", err, 2'b00);
        check_txq();
        chk("rst_single_release", rst_fall_cnt - f0, 1);
        chk("rst_fall_after_wdrdy", rst_fall_cyc, wdrdy_cyc + 1);
        chk("lock_to_done", done_cyc, rst_fall_cyc + lock_dly + 3);
    endtask

    initial begin
        int          d0;
        int          f0;
        int          n;
        logic [6:0]  addr_set [5];
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_mask  = '0;
        cmd_last  = 1'b0;
        addr_set[0] = 7'h08; addr_set[1] = 7'h09; addr_set[2] = 7'h0A;
        addr_set[3] = 7'h14; addr_set[4] = 7'h15;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        mem[8] = 16'hFFFF;
        sync_gmem();
        tick(3);
        chk("reset_outputs", {cmd_ready, busy, done, err, mmcm_rst, den, dwe},
            {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        chk("reset_drp_bus", {daddr, di}, 23'h0);
        rst = 1'b0;
        tick(3);

        // single command, fixed latencies
        $display("-- single command");
        lat = 3; lock_dly = 10;
        d0 = done_cnt; f0 = rst_fall_cnt; clear_q();
        send_cmd(7'h08, 16'h0041, 16'h1000, 1'b1);
        finish_ok(d0, f0);
        if (txq.size() == 2) begin
            chk("single_wdata", txq[1].d, 16'h1041);
            chk("single_latency", done_cyc, tx_cyc[0] + 21);
        end
        tick(3);

        // three commands with host idle gaps
        $display("-- three-command sequence");
        d0 = done_cnt; f0 = rst_fall_cnt; clear_q();
        send_cmd(7'h08, 16'h1234, 16'hFF00, 1'b0);
        wait_ready(); tick(4);
        send_cmd(7'h09, 16'hABCD, 16'h0F0F, 1'b0);
        wait_ready(); tick(4);
        send_cmd(7'h14, 16'h5555, 16'h0000, 1'b1);
        finish_ok(d0, f0);
        tick(3);

        // drdy never returned for the read
        $display("-- drdy timeout");
        d0 = done_cnt; clear_q(); no_drdy = 1;
        send_cmd(7'h08, 16'h0000, 16'h0000, 1'b1);
        wait_done(d0);
        chk("err_drdy_timeout", done_err, 2'b01);
        chk("no_write_issued", txq.size(), 1);
        if (txq.size() >= 1) begin
            chk("fail_rst_fall_cyc", rst_fall_cyc, tx_cyc[0] + 1 + DRDY_TO);
            chk("fail_done_cyc", done_cyc, tx_cyc[0] + 2 + DRDY_TO);
        end
        chk("fail_mmcm_rst_low", mmcm_rst, 0);
        no_drdy = 0; sync_gmem(); clear_q();
        tick(3);

        // lock never arrives
        $display("-- lock timeout");
        d0 = done_cnt; lock_hold = 1; lat = 2;
        send_cmd(7'h0A, 16'hC3C3, 16'hF0F0, 1'b1);
        wait_done(d0);
        chk("err_lock_timeout", done_err, 2'b10);
        chk("lock_timeout_cyc", done_cyc, rst_fall_cyc + LOCK_TO + 1);
        check_txq();
        lock_hold = 0; clear_q();
        tick(3);

        // reset pulse while waiting for the write's drdy
        $display("-- reset in WAIT_W");
        lat = 6;
        send_cmd(7'h09, 16'h7E7E, 16'h00FF, 1'b1);
        n = 0;
        while (txq.size() < 2 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        @(negedge clk_in);
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {mmcm_rst, den, busy, cmd_ready, done, err},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
        chk("async_rst_di", di, 0);
        @(negedge clk_in);
        rst = 1'b0;
        tick(12);
        sync_gmem(); clear_q();
        lat = 3;
        d0 = done_cnt; f0 = rst_fall_cnt;
        send_cmd(7'h15, 16'h0F00, 16'hF00F, 1'b1);
        finish_ok(d0, f0);
        tick(3);

        // spurious drdy in IDLE and in the RD cycle
        $display("-- spurious drdy");
        mem[7'h14] = 16'h00AA; gmem[7'h14] = 16'h00AA;
        lat = 2; clear_q();
        spur_idle = 1;
        tick(2);
        spur_rd = 1;
        d0 = done_cnt; f0 = rst_fall_cnt;
        send_cmd(7'h14, 16'h1200, 16'h00FF, 1'b1);
        finish_ok(d0, f0);
        if (txq.size() == 2) chk("spur_di_from_00AA", txq[1].d, 16'h12AA);
        tick(3);

        // randomized sequences
        for (int s = 0; s < 10; s++) begin
            int ncmd;
            ncmd = $urandom_range(1, 4);
            lock_dly = $urandom_range(0, 20);
            $display("-- random sequence %0d: %0d commands lock_dly=%0d", s, ncmd, lock_dly);
            d0 = done_cnt; f0 = rst_fall_cnt; clear_q();
            for (int i = 0; i < ncmd; i++) begin
                lat = $urandom_range(1, DRDY_TO);
                if (i > 0) begin
                    wait_ready();
                    tick($urandom_range(0, 4));
                end
                send_cmd(addr_set[$urandom_range(0, 4)], 16'($urandom), 16'($urandom), i == ncmd - 1);
            end
            finish_ok(d0, f0);
            tick($urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
